tx_cycle_sched: RTL and testbench
=================================

TX_CYCLE_SCHED -- requirements
Module: tx_cycle_sched

Interface
REQ-001 Parameter FREQ_IN_MHZ, default 40, SHALL set the input clock frequency in MHz (8-bit).
REQ-002 Parameter FREQ_OUT_HZ, default 5000, SHALL set the per-channel transmit rate in Hz (16-bit).
REQ-003 Parameter CH_NUM, default 2, range 1..4, SHALL set the number of staggered transmit channels.
REQ-004 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port nRst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port mkReady  in  1  SHALL enable cycle counting when high; counting holds when low.
REQ-007 Port txReady  in  CH_NUM  SHALL be the per-channel transmitter ready; low means the request is taken (busy).
REQ-008 Port ovrClr  in  1  SHALL clear all overrun flags and counters when high.
REQ-009 Port txStart  out  CH_NUM  SHALL be the per-channel registered transmit request.
REQ-010 Port cycleTick  out  1  SHALL pulse one clk at each base-period wrap.
REQ-011 Port ovrFlag  out  CH_NUM  SHALL be the per-channel sticky overrun flag.
REQ-012 Port ovrCnt  out  8*CH_NUM  SHALL be the per-channel saturating overrun counts; channel i in bits [8i+7:8i].

Function
REQ-013 PR SHALL be (1000000*FREQ_IN_MHZ/FREQ_OUT_HZ)-1 and STEP SHALL be (PR+1)/CH_NUM, integer division.
REQ-014 Elaboration SHALL fail if PR > 65535 or PR+1 < CH_NUM.
REQ-015 16-bit counter cnt SHALL increment by 1 per clk while mkReady=1, wrap PR->0, and hold while mkReady=0.
REQ-016 cycleTick SHALL be 1 in the clk following any enabled cycle with cnt==PR, else 0.
REQ-017 Channel i SHALL "fire" in any enabled cycle (mkReady=1) with cnt == PR - i*STEP.
REQ-018 On fire, txStart[i] SHALL be 1 from the next clk edge (1-cycle latency).
REQ-019 txStart[i] SHALL clear on the edge where txReady[i]=0 is sampled and channel i does not fire.
REQ-020 Fire and txReady[i]=0 in the same cycle: set SHALL win; txStart[i] stays/becomes 1.
REQ-021 Fire while txStart[i] is already 1 SHALL be an overrun: ovrFlag[i] set, ovrCnt[i] incremented, saturating at 255.
REQ-022 ovrClr=1 SHALL zero ovrFlag and ovrCnt on the next edge; a simultaneous overrun SHALL yield ovrFlag[i]=1, ovrCnt[i]=1.
REQ-023 mkReady falling mid-period SHALL freeze cnt; pending txStart SHALL still clear via txReady; no fire while frozen.
REQ-024 mkReady re-rising SHALL resume from the frozen cnt; no restart.

Reset
REQ-025 nRst=0 SHALL immediately force cnt=0, txStart=0, cycleTick=0, ovrFlag=0, ovrCnt=0.
REQ-026 After nRst deassert, first fire of channel 0 SHALL occur in the enabled cycle with cnt==PR (PR+1 enabled cycles).

Configuration
REQ-027 Macro TXCS_OVERRUN_CNT_EN defined: ovrCnt counters SHALL be implemented per REQ-021/022.
REQ-028 Macro TXCS_OVERRUN_CNT_EN undefined: ovrCnt SHALL be constant 0; ovrFlag and all other behaviour unchanged.

Verification (FREQ_IN_MHZ=1, FREQ_OUT_HZ=100000 -> PR=9; CH_NUM=2 -> STEP=5; ch0 fires at cnt 9, ch1 at cnt 4)
REQ-029 mkReady=1, txReady=1 after reset -> txStart[1] rises after 5 clk, txStart[0] after 10 clk, cycleTick pulses every 10 clk.
REQ-030 txReady[0] driven low 2 clk after txStart[0] rises -> txStart[0] clears the next clk; no overrun.
REQ-031 txReady held 1 for 3 periods -> ovrFlag=2'b11, ovrCnt[0]=2 (with macro) or 0 (without).
REQ-032 mkReady low for 7 clk at cnt=6 -> cnt holds 6, no fire/tick; resume reaches ch0 fire 3 enabled clk later.
REQ-033 ovrClr asserted in the same cycle as a ch0 overrun -> ovrFlag[0]=1, ovrCnt[0]=1.
REQ-034 nRst pulsed low asynchronously with txStart=2'b11 and ovrCnt nonzero -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/tx_cycle_sched.sv
// Staggered multi-channel transmit scheduler: one base-period counter fires CH_NUM channels
// at evenly spaced phases. Per-channel overrun counters are built only when TXCS_OVERRUN_CNT_EN is defined.
module tx_cycle_sched #(
  parameter int unsigned FREQ_IN_MHZ = 40,
  parameter int unsigned FREQ_OUT_HZ = 5000,
  parameter int unsigned CH_NUM      = 2
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  mkReady,
  input  logic [CH_NUM-1:0]     txReady,
  input  logic                  ovrClr,
  output logic [CH_NUM-1:0]     txStart,
  output logic                  cycleTick,
  output logic [CH_NUM-1:0]     ovrFlag,
  output logic [8*CH_NUM-1:0]   ovrCnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned OVR_W   = 8;
  localparam int unsigned OUT_DIV = (FREQ_OUT_HZ == 0) ? 1 : FREQ_OUT_HZ;
  localparam int unsigned CH_DIV  = (CH_NUM == 0) ? 1 : CH_NUM;
  localparam int unsigned PR_FULL = (32'd1000000 * FREQ_IN_MHZ) / OUT_DIV - 32'd1;
  localparam int unsigned STEP    = (PR_FULL + 32'd1) / CH_DIV;
  localparam logic [CNT_W-1:0] PR = CNT_W'(PR_FULL);

  // Reject configurations whose period does not fit the counter or cannot hold every channel phase.
  if (CH_NUM < 1 || CH_NUM > 4 || FREQ_OUT_HZ == 0 ||
      PR_FULL > 32'd65535 || PR_FULL + 32'd1 < CH_NUM) begin : g_bad_cfg
    $error("tx_cycle_sched: illegal parameter set");
  end

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              tick_d;
  logic [CH_NUM-1:0] start_d;
  logic [CH_NUM-1:0] flag_d;
  logic [CH_NUM-1:0] fire;
  logic [CH_NUM-1:0] overrun;
  logic              at_top;

  assign at_top = (cnt == PR);

  // Channel i fires at phase PR - i*STEP, so channel 0 lands on the period wrap.
  for (genvar i = 0; i < CH_NUM; i++) begin : g_fire
    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(PR_FULL - STEP * i);
    assign fire[i] = mkReady && (cnt == FIRE_AT);
  end

  assign overrun = fire & txStart;

  // Next-state: a fire always sets the request, even when txReady is sampled low.
  always_comb begin
    cnt_d   = cnt;
    tick_d  = 1'b0;
    start_d = txStart;
    flag_d  = ovrFlag;
    if (mkReady) begin
      cnt_d  = at_top ? '0 : cnt + CNT_W'(1);
      tick_d = at_top;
    end
    start_d = fire | (txStart & txReady);
    flag_d  = (ovrClr ? '0 : ovrFlag) | overrun;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt       <= '0;
      cycleTick <= 1'b0;
      txStart   <= '0;
      ovrFlag   <= '0;
    end else begin
      cnt       <= cnt_d;
      cycleTick <= tick_d;
      txStart   <= start_d;
      ovrFlag   <= flag_d;
    end
  end

`ifdef TXCS_OVERRUN_CNT_EN
  logic [CH_NUM-1:0][OVR_W-1:0] ovr_cnt;
  logic [CH_NUM-1:0][OVR_W-1:0] ovr_cnt_d;

  // Saturating counters; a clear coinciding with an overrun restarts the count at one.
  always_comb begin
    ovr_cnt_d = ovr_cnt;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (ovrClr) begin
        ovr_cnt_d[i] = {(OVR_W-1)'(0), overrun[i]};
      end else if (overrun[i] && ovr_cnt[i] != {OVR_W{1'b1}}) begin
        ovr_cnt_d[i] = ovr_cnt[i] + OVR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ovr_cnt <= '0;
    end else begin
      ovr_cnt <= ovr_cnt_d;
    end
  end

  assign ovrCnt = ovr_cnt;
`else
  assign ovrCnt = '0;
`endif

endmodule

// File: tb/tb_tx_cycle_sched.sv
// Directed bench for tx_cycle_sched (PR=9, STEP=5, two channels); expectations are queued
// by cycle number up front and a negedge monitor compares them as the run reaches each cycle.
module tb_tx_cycle_sched;

  localparam int T  = 4;
  localparam int T2 = T + 85;

  logic        clk = 1'b0;
  logic        nRst;
  logic        mkReady;
  logic [1:0]  txReady;
  logic        ovrClr;
  logic [1:0]  txStart;
  logic        cycleTick;
  logic [1:0]  ovrFlag;
  logic [15:0] ovrCnt;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    int         at;
    logic [1:0] st;
    logic       tk;
    logic [1:0] fl;
    logic [7:0] c1;
    logic [7:0] c0;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  e;
  string nm;

  tx_cycle_sched #(
    .FREQ_IN_MHZ(1),
    .FREQ_OUT_HZ(100000),
    .CH_NUM     (2)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .mkReady  (mkReady),
    .txReady  (txReady),
    .ovrClr   (ovrClr),
    .txStart  (txStart),
    .cycleTick(cycleTick),
    .ovrFlag  (ovrFlag),
    .ovrCnt   (ovrCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int at, input string name, input logic [1:0] st, input logic tk,
                    input logic [1:0] fl, input logic [7:0] c0, input logic [7:0] c1);
    exp_t x;
    x.at = at; x.st = st; x.tk = tk; x.fl = fl;
`ifdef TXCS_OVERRUN_CNT_EN
    x.c0 = c0; x.c1 = c1;
`else
    x.c0 = 8'd0; x.c1 = 8'd0;
`endif
    exp_q.push_back(x);
    name_q.push_back(name);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops every expectation due at this cycle and compares against the DUT.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (e.at < cyc) begin
        n_bad++;
        $display("FAIL %s: check missed, due cycle %0d, now cycle %0d", nm, e.at, cyc);
      end else if ({txStart, cycleTick, ovrFlag, ovrCnt} !== {e.st, e.tk, e.fl, e.c1, e.c0}) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got start=%b tick=%b flag=%b cnt=%h, expected start=%b tick=%b flag=%b cnt=%h",
                 nm, cyc, txStart, cycleTick, ovrFlag, ovrCnt, e.st, e.tk, e.fl, {e.c1, e.c0});
      end
    end
  end

  initial begin
    nRst = 1'b0; mkReady = 1'b0; txReady = 2'b11; ovrClr = 1'b0;

    ex(2,       "reset",          2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T,       "post_release",   2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+4,     "pre_ch1",        2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+5,     "ch1_rise",       2'b10, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+9,     "pre_ch0",        2'b10, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+10,    "ch0_rise_tick",  2'b11, 1'b1, 2'b00, 8'd0, 8'd0);
    ex(T+11,    "tick_one_cycle", 2'b11, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+15,    "ch1_ovr1",       2'b11, 1'b0, 2'b10, 8'd0, 8'd1);
    ex(T+20,    "ch0_ovr1",       2'b11, 1'b1, 2'b11, 8'd1, 8'd1);
    ex(T+30,    "three_periods",  2'b11, 1'b1, 2'b11, 8'd2, 8'd2);
    ex(T+35,    "pre_clr",        2'b11, 1'b0, 2'b11, 8'd2, 8'd3);
    ex(T+40,    "clr_with_ovr",   2'b11, 1'b1, 2'b01, 8'd1, 8'd0);
    ex(T+42,    "both_taken",     2'b00, 1'b0, 2'b01, 8'd1, 8'd0);
    ex(T+45,    "ch1_refire",     2'b10, 1'b0, 2'b01, 8'd1, 8'd0);
    ex(T+50,    "ch0_refire",     2'b11, 1'b1, 2'b01, 8'd1, 8'd0);
    ex(T+53,    "ready_low_clr",  2'b00, 1'b0, 2'b01, 8'd1, 8'd0);
    ex(T+55,    "ch1_no_ovr",     2'b10, 1'b0, 2'b01, 8'd1, 8'd0);
    ex(T+60,    "set_wins",       2'b11, 1'b1, 2'b01, 8'd1, 8'd0);
    ex(T+61,    "ch0_taken",      2'b10, 1'b0, 2'b01, 8'd1, 8'd0);
    ex(T+65,    "ch1_ovr_again",  2'b10, 1'b0, 2'b11, 8'd1, 8'd1);
    ex(T+69,    "frozen_taken",   2'b00, 1'b0, 2'b11, 8'd1, 8'd1);
    ex(T+70,    "frozen_no_tick", 2'b00, 1'b0, 2'b11, 8'd1, 8'd1);
    ex(T+76,    "resume_pre",     2'b00, 1'b0, 2'b11, 8'd1, 8'd1);
    ex(T+77,    "resume_fire",    2'b01, 1'b1, 2'b11, 8'd1, 8'd1);
    ex(T+82,    "pre_reset",      2'b11, 1'b0, 2'b11, 8'd1, 8'd1);
    ex(T+83,    "async_reset",    2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T+84,    "held_reset",     2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T2+4,    "r2_pre_ch1",     2'b00, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T2+5,    "r2_ch1",         2'b10, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T2+9,    "r2_pre_ch0",     2'b10, 1'b0, 2'b00, 8'd0, 8'd0);
    ex(T2+10,   "r2_ch0",         2'b11, 1'b1, 2'b00, 8'd0, 8'd0);
    ex(T2+2545, "cnt_253_254",    2'b11, 1'b0, 2'b11, 8'd253, 8'd254);
    ex(T2+2550, "cnt_254",        2'b11, 1'b1, 2'b11, 8'd254, 8'd254);
    ex(T2+2560, "cnt_255",        2'b11, 1'b1, 2'b11, 8'd255, 8'd255);
    ex(T2+2590, "cnt_saturated",  2'b11, 1'b1, 2'b11, 8'd255, 8'd255);
    ex(T2+2592, "final_clear",    2'b11, 1'b0, 2'b00, 8'd0, 8'd0);

    at_cyc(T);       nRst = 1'b1; mkReady = 1'b1;
    at_cyc(T+39);    ovrClr = 1'b1;
    at_cyc(T+40);    ovrClr = 1'b0;
    at_cyc(T+41);    txReady = 2'b00;
    at_cyc(T+42);    txReady = 2'b11;
    at_cyc(T+52);    txReady = 2'b00;
    at_cyc(T+53);    txReady = 2'b11;
    at_cyc(T+59);    txReady = 2'b10;
    at_cyc(T+61);    txReady = 2'b11;
    at_cyc(T+66);    mkReady = 1'b0;
    at_cyc(T+68);    txReady = 2'b01;
    at_cyc(T+69);    txReady = 2'b11;
    at_cyc(T+73);    mkReady = 1'b1;
    at_cyc(T+83);    #1 nRst = 1'b0;
    at_cyc(T2);      nRst = 1'b1;
    at_cyc(T2+2591); ovrClr = 1'b1;
    at_cyc(T2+2592); ovrClr = 1'b0;

    at_cyc(T2+2600);
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked, due cycle %0d, run ended at cycle %0d", nm, e.at, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
